tt_equiv_sweeper: RTL and testbench

- Sequential truth-table sweeper and equivalence checker for two N-variable Boolean functions, each supplied as a 2^N-bit truth table.
- Steps through every minterm once per accepted beat and streams each row (index, f_a, f_b, diff) over a valid/ready interface.
- Counts mismatches and records the first differing minterm.
- Generalises the team's two-input expression pair (s1, s2 checked by exhaustive x/y stimulus) into a parametrised, clocked, self-checking block usable as a bench helper or on-chip BIST.

---
 rtl/tt_equiv_sweeper_if.sv | 22 ++
 rtl/tt_equiv_sweeper.sv | 123 ++++++++++++
 tb/tb_tt_equiv_sweeper.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_equiv_sweeper_if.sv
// Row stream of the truth-table sweeper: one minterm per beat, with
// valid/ready flow control.
interface tt_equiv_sweeper_if #(
   parameter int N = 2
);
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_idx;
   logic         out_a;
   logic         out_b;
   logic         out_diff;

   modport master (
      output out_valid, out_idx, out_a, out_b, out_diff,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_idx, out_a, out_b, out_diff,
      output out_ready
   );
endinterface

// File: rtl/tt_equiv_sweeper.sv
// Walks every minterm of two latched N-variable truth tables, streams each row
// and keeps the mismatch count, the lowest differing minterm and an equal flag.
module tt_equiv_sweeper #(
   parameter  int N  = 2,
   localparam int TT = 2**N
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [TT-1:0]        tt_a,
   input  logic [TT-1:0]        tt_b,
   tt_equiv_sweeper_if.master   out,
   output logic                 busy,
   output logic                 done,
   output logic                 equal,
   output logic [N:0]           mism_cnt,
   output logic                 first_vld,
   output logic [N-1:0]         first_idx
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  idx_q;
   logic [TT-1:0] ta_q;
   logic [TT-1:0] tb_q;
   logic [N:0]    mism_q;
   logic [N:0]    mism_d;
   logic          fvld_q;
   logic [N-1:0]  fidx_q;
   logic          equal_q;
   logic          done_q;
   logic          busy_q;
   logic          valid_q;

   logic          row_a;
   logic          row_b;
   logic          row_diff;
   logic          xfer;
   logic          last_row;

   assign row_a    = ta_q[idx_q];
   assign row_b    = tb_q[idx_q];
   assign row_diff = row_a ^ row_b;
   assign xfer     = valid_q & out.out_ready;
   assign last_row = (idx_q == N'(TT - 1));
   // mism_d is also used to form equal on the final beat, so the last row counts
   assign mism_d   = mism_q + {{N{1'b0}}, row_diff};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ta_q    <= '0;
         tb_q    <= '0;
         mism_q  <= '0;
         fvld_q  <= 1'b0;
         fidx_q  <= '0;
         equal_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  ta_q    <= tt_a;
                  tb_q    <= tt_b;
                  idx_q   <= '0;
                  mism_q  <= '0;
                  fvld_q  <= 1'b0;
                  fidx_q  <= '0;
                  equal_q <= 1'b0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               if (xfer) begin
                  mism_q <= mism_d;
                  if (row_diff && !fvld_q) begin
                     fvld_q <= 1'b1;
                     fidx_q <= idx_q;
                  end
                  if (last_row) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     equal_q <= (mism_d == '0);
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out.out_valid = valid_q;
   assign out.out_idx   = idx_q;
   assign out.out_a     = row_a;
   assign out.out_b     = row_b;
   assign out.out_diff  = row_diff;

   assign busy      = busy_q;
   assign done      = done_q;
   assign equal     = equal_q;
   assign mism_cnt  = mism_q;
   assign first_vld = fvld_q;
   assign first_idx = fidx_q;

endmodule

// File: tb/tb_tt_equiv_sweeper.sv
// Scoreboard bench for tt_equiv_sweeper: an N=2 and an N=3 instance share one
// clock; stimulus queues expected rows/results, a negedge monitor checks them.
module tb_tt_equiv_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start2, start3;
   logic [3:0] ta2, tb2;
   logic [7:0] ta3, tb3;
   logic       busy2, done2, equal2, fvld2;
   logic [2:0] mism2;
   logic [1:0] fidx2;
   logic       busy3, done3, equal3, fvld3;
   logic [3:0] mism3;
   logic [2:0] fidx3;

   tt_equiv_sweeper_if #(.N(2)) if2 ();
   tt_equiv_sweeper_if #(.N(3)) if3 ();

   tt_equiv_sweeper #(.N(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .tt_a(ta2), .tt_b(tb2),
      .out(if2.master), .busy(busy2), .done(done2), .equal(equal2),
      .mism_cnt(mism2), .first_vld(fvld2), .first_idx(fidx2)
   );

   tt_equiv_sweeper #(.N(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .tt_a(ta3), .tt_b(tb3),
      .out(if3.master), .busy(busy3), .done(done3), .equal(equal3),
      .mism_cnt(mism3), .first_vld(fvld3), .first_idx(fidx3)
   );

   typedef struct {int w; int idx; int a; int b; int d;} row_t;
   typedef struct {int w; int mism; int fvld; int fidx; int eq; int lat;} res_t;
   typedef struct {int w; int valid; int busy; int done; int eq; int mism; int fvld;
                   int fidx; int chk_row; int idx; int a; int b; int d;} snap_t;
   typedef struct {int valid; int ready; int idx; int a; int b; int d; int busy;
                   int done; int eq; int mism; int fvld; int fidx;} view_t;

   row_t  rq[$];
   res_t  resq[$];
   snap_t sq[$];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int start_cyc  = 0;
   int done_cnt[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, int w, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s (N=%0d): got %0d expected %0d", nm, w + 2, act, exp);
      end
   endtask

   function automatic view_t get_view(int w);
      view_t v;
      if (w == 0) begin
         v.valid = int'(if2.out_valid); v.ready = int'(if2.out_ready);
         v.idx = int'(if2.out_idx); v.a = int'(if2.out_a); v.b = int'(if2.out_b);
         v.d = int'(if2.out_diff); v.busy = int'(busy2); v.done = int'(done2);
         v.eq = int'(equal2); v.mism = int'(mism2); v.fvld = int'(fvld2);
         v.fidx = int'(fidx2);
      end else begin
         v.valid = int'(if3.out_valid); v.ready = int'(if3.out_ready);
         v.idx = int'(if3.out_idx); v.a = int'(if3.out_a); v.b = int'(if3.out_b);
         v.d = int'(if3.out_diff); v.busy = int'(busy3); v.done = int'(done3);
         v.eq = int'(equal3); v.mism = int'(mism3); v.fvld = int'(fvld3);
         v.fidx = int'(fidx3);
      end
      return v;
   endfunction

   // Monitor: all row/result/snapshot comparisons happen mid-cycle
   always @(negedge clk) begin : monitor
      view_t v;
      row_t  r;
      res_t  e;
      snap_t s;
      for (int w = 0; w < 2; w++) begin
         v = get_view(w);
         if (sq.size() > 0 && sq[0].w == w) begin
            s = sq.pop_front();
            chk("snap valid", w, v.valid, s.valid);
            chk("snap busy",  w, v.busy,  s.busy);
            chk("snap done",  w, v.done,  s.done);
            chk("snap equal", w, v.eq,    s.eq);
            chk("snap mism",  w, v.mism,  s.mism);
            chk("snap fvld",  w, v.fvld,  s.fvld);
            chk("snap fidx",  w, v.fidx,  s.fidx);
            if (s.chk_row != 0) begin
               chk("snap idx",  w, v.idx, s.idx);
               chk("snap a",    w, v.a,   s.a);
               chk("snap b",    w, v.b,   s.b);
               chk("snap diff", w, v.d,   s.d);
            end
         end
         if (v.valid != 0) begin
            if (rq.size() == 0 || rq[0].w != w) begin
               chk("unexpected row", w, v.idx, -1);
            end else begin
               r = rq[0];
               chk("row idx",  w, v.idx, r.idx);
               chk("row a",    w, v.a,   r.a);
               chk("row b",    w, v.b,   r.b);
               chk("row diff", w, v.d,   r.d);
               chk("row busy", w, v.busy, 1);
               if (v.ready != 0) void'(rq.pop_front());
            end
         end
         if (v.done != 0) begin
            done_cnt[w]++;
            if (resq.size() == 0 || resq[0].w != w) begin
               chk("unexpected done", w, 1, 0);
            end else begin
               e = resq.pop_front();
               chk("res mism",  w, v.mism, e.mism);
               chk("res fvld",  w, v.fvld, e.fvld);
               chk("res fidx",  w, v.fidx, e.fidx);
               chk("res equal", w, v.eq,   e.eq);
               chk("done busy", w, v.busy, 1);
               chk("done valid", w, v.valid, 0);
               chk("rows left", w, rq.size(), 0);
               if (e.lat >= 0) chk("done latency", w, cyc - start_cyc + 1, e.lat);
            end
         end
      end
   end

   task automatic drive(int w, logic s, logic [7:0] a, logic [7:0] b);
      if (w == 0) begin
         start2 = s; ta2 = a[3:0]; tb2 = b[3:0];
      end else begin
         start3 = s; ta3 = a; tb3 = b;
      end
   endtask

   task automatic set_ready(int w, logic r);
      if (w == 0) if2.out_ready = r;
      else        if3.out_ready = r;
   endtask

   function automatic int cur_idx(int w);
      return (w == 0) ? int'(if2.out_idx) : int'(if3.out_idx);
   endfunction

   // Reference: rows and results straight from the tables
   task automatic expect_sweep(int w, logic [7:0] a, logic [7:0] b, int lat);
      int   nt;
      int   mism;
      int   fidx;
      row_t r;
      res_t e;
      nt   = (w == 0) ? 4 : 8;
      mism = 0;
      fidx = 0;
      for (int i = nt - 1; i >= 0; i--) begin
         if (a[i] != b[i]) begin
            mism++;
            fidx = i;
         end
      end
      for (int i = 0; i < nt; i++) begin
         r = '{w, i, int'(a[i]), int'(b[i]), int'(a[i] ^ b[i])};
         rq.push_back(r);
      end
      e = '{w, mism, (mism != 0) ? 1 : 0, fidx, (mism == 0) ? 1 : 0, lat};
      resq.push_back(e);
   endtask

   task automatic sweep(int w, logic [7:0] a, logic [7:0] b, int stall_at,
                        int stall_len, bit rnd, bit restart);
      int nt;
      int base;
      int stalled;
      nt      = (w == 0) ? 4 : 8;
      stalled = 0;
      expect_sweep(w, a, b, rnd ? -1 : nt + 1 + stall_len);
      base = done_cnt[w];
      @(posedge clk); #1;
      drive(w, 1'b1, a, b);
      set_ready(w, 1'b1);
      @(posedge clk); #1;
      start_cyc = cyc;
      for (int k = 0; k < 400 && done_cnt[w] == base; k++) begin
         if (restart && k == 1) drive(w, 1'b1, ~a, a);
         else drive(w, 1'b0, 8'($urandom), 8'($urandom));
         if (stall_len > 0 && cur_idx(w) == stall_at && stalled < stall_len) begin
            set_ready(w, 1'b0);
            stalled++;
         end else begin
            set_ready(w, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         end
         @(posedge clk); #1;
      end
      if (done_cnt[w] == base) begin
         chk("done timeout", w, 0, 1);
         rq.delete();
         resq.delete();
      end
      drive(w, 1'b0, a, b);
      set_ready(w, 1'b1);
   endtask

   task automatic push_snap(int w, int valid, int busy, int eq, int mism, int fvld,
                            int fidx, int chk_row);
      snap_t s;
      s = '{w, valid, busy, 0, eq, mism, fvld, fidx, chk_row, 0, 0, 0, 0};
      sq.push_back(s);
   endtask

   initial begin
      logic [7:0] ra, rb;
      int         rw;
      rst_n = 1'b0;
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      drive(0, 1'b0, 8'h0, 8'h0);
      drive(1, 1'b0, 8'h0, 8'h0);
      set_ready(0, 1'b1);
      set_ready(1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      push_snap(0, 0, 0, 0, 0, 0, 0, 1);
      push_snap(1, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Identical functions, mismatching pair, then retention with no start
      sweep(0, 8'h0B, 8'h0B, -1, 0, 1'b0, 1'b0);
      sweep(0, 8'h0B, 8'h08, -1, 0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         drive(0, 1'b0, 8'($urandom), 8'($urandom));
      end
      push_snap(0, 0, 0, 0, 2, 1, 0, 0);
      @(posedge clk); #1;

      sweep(0, 8'h0B, 8'h0B, 2, 3, 1'b0, 1'b0);
      push_snap(0, 0, 0, 1, 0, 0, 0, 0);
      sweep(1, 8'hFF, 8'h7F, -1, 0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      push_snap(1, 0, 0, 0, 1, 1, 7, 0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of an N=2 sweep
      expect_sweep(0, 8'h0B, 8'h08, 5);
      drive(0, 1'b1, 8'h0B, 8'h08);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h0B, 8'h08);
      for (int k = 0; k < 20 && cur_idx(0) != 1; k++) begin
         @(posedge clk); #1;
      end
      chk("reach idx1", 0, cur_idx(0), 1);
      rst_n = 1'b0;
      rq.delete();
      resq.delete();
      push_snap(0, 0, 0, 0, 0, 0, 0, 1);
      push_snap(1, 0, 0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      sweep(0, 8'h0B, 8'h0B, -1, 0, 1'b0, 1'b0);

      // Random tables with random backpressure
      for (int n = 0; n < 12; n++) begin
         rw = int'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
         if (rw == 0) begin
            ra = ra & 8'h0F;
            rb = rb & 8'h0F;
         end
         sweep(rw, ra, rb, -1, 0, 1'b1, 1'b0);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("rows drained", 0, rq.size(), 0);
      chk("results drained", 0, resq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
